// File: rtl/ring_osc_freq_meter.sv
// ring_osc_freq_meter: gates a ring oscillator on, then counts its synchronised
// rising edges over a fixed clk window and reports the count.
module ring_osc_freq_meter #(
   parameter int GATE_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             osc_in,
   output logic             osc_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);
   localparam int MAX_C = GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TW = $clog2(MAX_C + 1);
   localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] G_LAST = TW'(GATE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
   logic             sat_q, sat_d, ovf_q, ovf_d, osc_en_q, osc_en_d;
   logic             osc_edge;
   assign osc_edge = s2_q & ~s3_q;
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TW'(1);
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (start) state_d = SETTLE;
         end
         SETTLE: if (timer_q == S_LAST) begin
            state_d = MEASURE;
            timer_d = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
         end
         MEASURE: begin
            if (osc_edge && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == '1) sat_d = 1'b1;
            // result latched on the way into DONE so it is valid alongside the done pulse
            if (timer_q == G_LAST) begin
               state_d = DONE;
               count_d = cnt_d;
               ovf_d   = sat_d;
            end
         end
         DONE: begin
            state_d = IDLE;
            timer_d = '0;
         end
         default: state_d = IDLE;
      endcase
      osc_en_d = (state_d == SETTLE) || (state_d == MEASURE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         timer_q  <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         osc_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         s1_q     <= osc_in;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         timer_q  <= timer_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         osc_en_q <= osc_en_d;
      end
   end
   assign osc_en   = osc_en_q;
   assign busy     = state_q != IDLE;
   assign done     = state_q == DONE;
   assign count    = count_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// tb_ring_osc_freq_meter: directed bench for a default meter and an 8-bit-count meter
// sharing clock, reset and oscillator stimulus.
module tb_ring_osc_freq_meter;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start8 = 1'b0, osc_in = 1'b0;
   logic        osc_en, busy, done, overflow;
   logic [15:0] count;
   logic        osc_en8, busy8, done8, overflow8;
   logic [7:0]  count8;
   int          osc_half = 0, ph = 0;
   int          vectors = 0, errors = 0;

   ring_osc_freq_meter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .osc_in(osc_in), .osc_en(osc_en),
      .busy(busy), .done(done), .count(count), .overflow(overflow)
   );
   ring_osc_freq_meter #(.CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .osc_in(osc_in), .osc_en(osc_en8),
      .busy(busy8), .done(done8), .count(count8), .overflow(overflow8)
   );

   always #5 clk = ~clk;

   // osc_half < 0: random bits; 0: dead oscillator; else toggle every osc_half clks
   always @(negedge clk) begin
      if (osc_half < 0) osc_in = 1'($urandom);
      else if (osc_half == 0) begin
         osc_in = 1'b0;
         ph = 0;
      end else begin
         ph++;
         if (ph >= osc_half) begin
            ph = 0;
            osc_in = ~osc_in;
         end
      end
   end

   // Entered at a negedge in an IDLE cycle (cycle 0); returns at the negedge of the done cycle.
   task automatic measure(input bit narrow, input bit pulse, output int done_cyc,
                          output int en_err, output logic [15:0] cnt, output logic ovf);
      logic d, e;
      done_cyc = -1;
      en_err   = 0;
      cnt      = '0;
      ovf      = 1'b0;
      if (narrow) start8 = 1'b1;
      else start = 1'b1;
      for (int n = 1; n <= 1200 && done_cyc < 0; n++) begin
         @(negedge clk);
         start  = 1'b0;
         start8 = 1'b0;
         d = narrow ? done8 : done;
         e = narrow ? osc_en8 : osc_en;
         if ((n <= 1040 && e !== 1'b1) || (n > 1040 && e !== 1'b0)) en_err++;
         if (d === 1'b1) begin
            done_cyc = n;
            cnt = narrow ? {8'h00, count8} : count;
            ovf = narrow ? overflow8 : overflow;
         end
         if (pulse && (n == 5 || n == 500 || n == 1041)) begin
            if (narrow) start8 = 1'b1;
            else start = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      osc_half = -1;
      rst_n = 1'b0;
      repeat (20) begin
         @(negedge clk);
         start  = 1'($urandom);
         start8 = 1'($urandom);
         #1;
         vectors++;
         if ({osc_en, busy, done, count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got osc_en=%b busy=%b done=%b count=%0d overflow=%b, want all 0",
                     osc_en, busy, done, count, overflow);
         end
         vectors++;
         if ({osc_en8, busy8, done8, count8, overflow8} !== '0) begin
            errors++;
            $display("FAIL reset_outputs8: got osc_en=%b busy=%b done=%b count=%0d overflow=%b, want all 0",
                     osc_en8, busy8, done8, count8, overflow8);
         end
      end
      start = 1'b0;
      start8 = 1'b0;
      osc_half = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) begin
         @(negedge clk);
         vectors++;
         if ({osc_en, busy, osc_en8, busy8} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got osc_en=%b busy=%b osc_en8=%b busy8=%b, want 0",
                     osc_en, busy, osc_en8, busy8);
         end
      end
   endtask

   task automatic test_freq;
      int dc, ee;
      logic [15:0] c;
      logic o;
      osc_half = 4;
      repeat (8) @(negedge clk);
      measure(1'b0, 1'b0, dc, ee, c, o);
      vectors++;
      if (dc !== 1041) begin errors++; $display("FAIL freq_done_cycle: got %0d want 1041", dc); end
      vectors++;
      if (ee !== 0) begin errors++; $display("FAIL freq_osc_en_window: got %0d bad cycles want 0", ee); end
      vectors++;
      if (c < 127 || c > 129) begin errors++; $display("FAIL freq_count: got %0d want 128+/-1", c); end
      vectors++;
      if (o !== 1'b0) begin errors++; $display("FAIL freq_overflow: got %b want 0", o); end
   endtask

   task automatic test_dead;
      int dc, ee;
      logic [15:0] c;
      logic o;
      osc_half = 0;
      repeat (8) @(negedge clk);
      measure(1'b0, 1'b0, dc, ee, c, o);
      vectors++;
      if (dc !== 1041) begin errors++; $display("FAIL dead_done_cycle: got %0d want 1041", dc); end
      vectors++;
      if (c !== 16'd0) begin errors++; $display("FAIL dead_count: got %0d want 0", c); end
      vectors++;
      if (o !== 1'b0) begin errors++; $display("FAIL dead_overflow: got %b want 0", o); end
   endtask

   task automatic test_overflow;
      int dc, ee;
      logic [15:0] c;
      logic o;
      osc_half = 2;
      repeat (8) @(negedge clk);
      measure(1'b1, 1'b0, dc, ee, c, o);
      vectors++;
      if (dc !== 1041) begin errors++; $display("FAIL sat_done_cycle: got %0d want 1041", dc); end
      vectors++;
      if (c !== 16'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", c); end
      vectors++;
      if (o !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b want 1", o); end
      osc_half = 8;
      repeat (4) @(negedge clk);
      measure(1'b1, 1'b0, dc, ee, c, o);
      vectors++;
      if (c < 63 || c > 65) begin errors++; $display("FAIL slow_count8: got %0d want 64+/-1", c); end
      vectors++;
      if (o !== 1'b0) begin errors++; $display("FAIL slow_overflow8: got %b want 0", o); end
   endtask

   task automatic test_back_to_back;
      int dc, ee;
      logic [15:0] c;
      logic o;
      osc_half = 4;
      repeat (4) @(negedge clk);
      measure(1'b0, 1'b1, dc, ee, c, o);
      vectors++;
      if (dc !== 1041) begin errors++; $display("FAIL ignored_start_done_cycle: got %0d want 1041", dc); end
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL no_restart: got busy=%b done=%b want 0 0", busy, done);
      end
      measure(1'b0, 1'b0, dc, ee, c, o);
      vectors++;
      if (dc !== 1041) begin errors++; $display("FAIL second_done_cycle: got %0d want 1041", dc); end
      vectors++;
      if (c < 127 || c > 129) begin errors++; $display("FAIL second_count: got %0d want 128+/-1", c); end
   endtask

   task automatic test_reset_mid;
      int dc, ee, nd;
      logic [15:0] c;
      logic o;
      osc_half = 4;
      repeat (4) @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= 517; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({osc_en, busy, done, count, overflow} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got osc_en=%b busy=%b done=%b count=%0d overflow=%b, want all 0",
                  osc_en, busy, done, count, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (600) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) nd++;
      end
      vectors++;
      if (nd !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d active cycles want 0", nd); end
      measure(1'b0, 1'b0, dc, ee, c, o);
      vectors++;
      if (dc !== 1041) begin errors++; $display("FAIL post_reset_done_cycle: got %0d want 1041", dc); end
      vectors++;
      if (c < 127 || c > 129) begin errors++; $display("FAIL post_reset_count: got %0d want 128+/-1", c); end
   endtask

   initial begin
      test_reset;
      test_freq;
      test_dead;
      test_overflow;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
